// File: rtl/banco_reg_pkg.sv
// Shared constants and helpers for the banco_reg_multi register bank.
package banco_reg_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int MAX_NUM_REGS   = 64;
  localparam logic [63:0] ZERO_WORD = 64'h0;

  // A bank of one register still needs a one-bit address.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/banco_reg_scoreboard.sv
// Per-register busy tracking and read-accept decision for banco_reg_multi.
// Build option BANCO_REG_BYPASS_EN: a write's busy-clear is seen by a read in the same cycle.
module banco_reg_scoreboard
  import banco_reg_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ZERO_REG = 0,
  parameter int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_REGS-1:0] wr_hit,
  input  logic                Reserva,
  input  logic [ADDR_W-1:0]   IdReserva,
  input  logic                Leitura,
  input  logic [ADDR_W-1:0]   Fonte1,
  input  logic [ADDR_W-1:0]   Fonte2,
  output logic                aceita,
  output logic                Ocupado
);

  logic [NUM_REGS-1:0] busy_q, busy_d, rsv_hit, eff_busy;
  logic                blk1, blk2;

  always_comb begin
    rsv_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rsv_hit[i] = Reserva && (IdReserva == ADDR_W'(i)) && !(ZERO_REG != 0 && i == 0);
    end
  end

  // Reservation is applied after the clear so a same-edge new producer wins.
  assign busy_d = (busy_q & ~wr_hit) | rsv_hit;

`ifdef BANCO_REG_BYPASS_EN
  assign eff_busy = busy_q & ~wr_hit;
`else
  assign eff_busy = busy_q;
`endif

  // Out-of-range addresses match no entry and therefore never block.
  always_comb begin
    blk1 = 1'b0;
    blk2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (Fonte1 == ADDR_W'(i) && eff_busy[i]) blk1 = 1'b1;
      if (Fonte2 == ADDR_W'(i) && eff_busy[i]) blk2 = 1'b1;
    end
  end

  assign aceita  = Leitura && !blk1 && !blk2;
  assign Ocupado = Leitura && !aceita;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/banco_reg_multi.sv
// Parametrised register bank: one write port, two registered read ports, busy scoreboard.
// Build option BANCO_REG_BYPASS_EN: same-cycle reads of a written register return the new data.
module banco_reg_multi
  import banco_reg_pkg::*;
#(
  parameter  int DATA_W   = DEFAULT_DATA_W,
  parameter  int NUM_REGS = 4,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Escrita,
  input  logic [ADDR_W-1:0] IdReg,
  input  logic [DATA_W-1:0] Dado,
  input  logic              Leitura,
  input  logic [ADDR_W-1:0] Fonte1,
  input  logic [ADDR_W-1:0] Fonte2,
  input  logic              Reserva,
  input  logic [ADDR_W-1:0] IdReserva,
  output logic [DATA_W-1:0] DadoLido1,
  output logic [DATA_W-1:0] DadoLido2,
  output logic              Valido,
  output logic              Ocupado
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [DATA_W-1:0]   rd1, rd2;
  logic                aceita;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = Escrita && (IdReg == ADDR_W'(i)) && !(ZERO_REG != 0 && i == 0);
    end
  end

  banco_reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .Clock     (Clock),
    .Reset     (Reset),
    .wr_hit    (wr_hit),
    .Reserva   (Reserva),
    .IdReserva (IdReserva),
    .Leitura   (Leitura),
    .Fonte1    (Fonte1),
    .Fonte2    (Fonte2),
    .aceita    (aceita),
    .Ocupado   (Ocupado)
  );

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd1 = DATA_W'(ZERO_WORD);
    rd2 = DATA_W'(ZERO_WORD);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
`ifdef BANCO_REG_BYPASS_EN
        if (Fonte1 == ADDR_W'(i)) rd1 = wr_hit[i] ? Dado : regs_q[i];
        if (Fonte2 == ADDR_W'(i)) rd2 = wr_hit[i] ? Dado : regs_q[i];
`else
        if (Fonte1 == ADDR_W'(i)) rd1 = regs_q[i];
        if (Fonte2 == ADDR_W'(i)) rd2 = regs_q[i];
`endif
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(ZERO_WORD);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) regs_q[i] <= Dado;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      DadoLido1 <= DATA_W'(ZERO_WORD);
      DadoLido2 <= DATA_W'(ZERO_WORD);
      Valido    <= 1'b0;
    end else begin
      Valido <= aceita;
      if (aceita) begin
        DadoLido1 <= rd1;
        DadoLido2 <= rd2;
      end
    end
  end

endmodule

// File: tb/tb_banco_reg_multi.sv
// Self-checking bench: two instances (4 regs, and 5 regs with zero register) against a behavioural model.
module tb_banco_reg_multi;

`ifdef BANCO_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int NR [2] = '{4, 5};
  localparam int ZR [2] = '{0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        esc, lei, rsv;
  logic [2:0]  idreg, f1, f2, idr;
  logic [31:0] dado;

  logic [31:0] q1_0, q2_0, q1_1, q2_1;
  logic        v_0, v_1, oc_0, oc_1;

  int checks   = 0;
  int failures = 0;
  bit active   = 1'b0;

  always #5 clk = ~clk;

  banco_reg_multi #(.DATA_W(32), .NUM_REGS(4), .ZERO_REG(0)) dut0 (
    .Clock(clk), .Reset(rst), .Escrita(esc), .IdReg(idreg[1:0]), .Dado(dado),
    .Leitura(lei), .Fonte1(f1[1:0]), .Fonte2(f2[1:0]), .Reserva(rsv), .IdReserva(idr[1:0]),
    .DadoLido1(q1_0), .DadoLido2(q2_0), .Valido(v_0), .Ocupado(oc_0)
  );

  banco_reg_multi #(.DATA_W(32), .NUM_REGS(5), .ZERO_REG(1)) dut1 (
    .Clock(clk), .Reset(rst), .Escrita(esc), .IdReg(idreg), .Dado(dado),
    .Leitura(lei), .Fonte1(f1), .Fonte2(f2), .Reserva(rsv), .IdReserva(idr),
    .DadoLido1(q1_1), .DadoLido2(q2_1), .Valido(v_1), .Ocupado(oc_1)
  );

  // Behavioural model: register contents, busy flags and expected outputs per instance.
  logic [31:0] mmem  [2][8] = '{default: '0};
  logic        mbusy [2][8] = '{default: 1'b0};
  logic [31:0] exp_d1 [2] = '{default: '0};
  logic [31:0] exp_d2 [2] = '{default: '0};
  logic        exp_v  [2] = '{default: 1'b0};

  function automatic int maddr(int k, logic [2:0] a);
    return (k == 0) ? int'(a[1:0]) : int'(a);
  endfunction

  function automatic bit mvalid(int k, int a);
    return (a < NR[k]) && !(ZR[k] == 1 && a == 0);
  endfunction

  function automatic bit wr_same(int k, int a);
    return BYP && esc && mvalid(k, a) && maddr(k, idreg) == a;
  endfunction

  function automatic logic [31:0] mval(int k, int a);
    if (!mvalid(k, a)) return 32'h0;
    if (wr_same(k, a)) return dado;
    return mmem[k][a];
  endfunction

  function automatic bit mblocked(int k, int a);
    return mvalid(k, a) && mbusy[k][a] && !wr_same(k, a);
  endfunction

  function automatic bit maccept(int k);
    return lei && !mblocked(k, maddr(k, f1)) && !mblocked(k, maddr(k, f2));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        exp_d1[k] <= '0;
        exp_d2[k] <= '0;
        exp_v[k]  <= 1'b0;
        for (int a = 0; a < 8; a++) begin
          mmem[k][a]  <= '0;
          mbusy[k][a] <= 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_v[k] <= maccept(k);
        if (maccept(k)) begin
          exp_d1[k] <= mval(k, maddr(k, f1));
          exp_d2[k] <= mval(k, maddr(k, f2));
        end
        if (esc && mvalid(k, maddr(k, idreg))) begin
          mmem[k][maddr(k, idreg)]  <= dado;
          mbusy[k][maddr(k, idreg)] <= 1'b0;
        end
        if (rsv && mvalid(k, maddr(k, idr))) mbusy[k][maddr(k, idr)] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      chk("m0_d1", q1_0, exp_d1[0]);
      chk("m0_d2", q2_0, exp_d2[0]);
      chk("m0_v",  32'(v_0), 32'(exp_v[0]));
      chk("m0_oc", 32'(oc_0), 32'(lei && !maccept(0)));
      chk("m1_d1", q1_1, exp_d1[1]);
      chk("m1_d2", q2_1, exp_d2[1]);
      chk("m1_v",  32'(v_1), 32'(exp_v[1]));
      chk("m1_oc", 32'(oc_1), 32'(lei && !maccept(1)));
    end
  end

  task automatic idle();
    esc = 0; lei = 0; rsv = 0;
    idreg = 0; f1 = 0; f2 = 0; idr = 0; dado = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d1", q1_1, 32'h0);
    chk("rst_v",  32'(v_1), 32'h0);
    chk("rst_v0", 32'(v_0), 32'h0);
    rst = 1'b0;
    active = 1'b1;

    lei = 1; f1 = 1; f2 = 2; cyc(); idle();
    chk("t1_d1", q1_1, 32'h0);
    chk("t1_d2", q2_1, 32'h0);
    chk("t1_v",  32'(v_1), 32'h1);

    esc = 1; idreg = 2; dado = 32'hDEADBEEF; cyc(); idle();
    lei = 1; f1 = 2; f2 = 2; cyc(); idle();
    chk("t2_d1", q1_1, 32'hDEADBEEF);
    chk("t2_d2", q2_1, 32'hDEADBEEF);
    chk("t2_d1_0", q1_0, 32'hDEADBEEF);

    rsv = 1; idr = 1; cyc(); idle();
    lei = 1; f1 = 1; f2 = 2; #1;
    chk("t3_oc", 32'(oc_1), 32'h1);
    cyc(); idle();
    chk("t3_v",    32'(v_1), 32'h0);
    chk("t3_hold", q1_1, 32'hDEADBEEF);
    esc = 1; idreg = 1; dado = 32'h5; cyc(); idle();
    lei = 1; f1 = 1; f2 = 1; cyc(); idle();
    chk("t3_d1", q1_1, 32'h5);
    chk("t3_v2", 32'(v_1), 32'h1);

    esc = 1; idreg = 3; dado = 32'h11; cyc(); idle();
    esc = 1; idreg = 3; dado = 32'hA5; lei = 1; f1 = 3; f2 = 3; cyc(); idle();
    chk("t4_byp", q1_1, BYP ? 32'hA5 : 32'h11);
    lei = 1; f1 = 3; f2 = 1; cyc(); idle();
    chk("t4_after", q1_1, 32'hA5);

    esc = 1; idreg = 0; dado = 32'h7; cyc(); idle();
    lei = 1; f1 = 0; f2 = 6; cyc(); idle();
    chk("t5_z0", q1_1, 32'h0);
    chk("t5_oor", q2_1, 32'h0);
    chk("t5_v", 32'(v_1), 32'h1);
    rsv = 1; idr = 0; cyc(); idle();
    lei = 1; f1 = 0; f2 = 0; #1;
    chk("t5_oc", 32'(oc_1), 32'h0);
    cyc(); idle();

    rsv = 1; idr = 2; esc = 1; idreg = 2; dado = 32'h33; cyc(); idle();
    lei = 1; f1 = 2; f2 = 3; #1;
    chk("t6_oc", 32'(oc_1), 32'h1);
    cyc(); idle();
    chk("t6_v", 32'(v_1), 32'h0);

    rsv = 1; idr = 7; esc = 1; idreg = 5; dado = 32'h99; cyc(); idle();
    lei = 1; f1 = 7; f2 = 5; #1;
    chk("t7_oc", 32'(oc_1), 32'h0);
    cyc(); idle();
    chk("t7_d1", q1_1, 32'h0);
    chk("t7_d2", q2_1, 32'h0);

    esc = 1; idreg = 2; dado = 32'h44; lei = 1; f1 = 2; f2 = 2; cyc(); idle();
    chk("t8_v", 32'(v_1), 32'(BYP));
    lei = 1; f1 = 2; f2 = 4; cyc(); idle();
    chk("t8_d1", q1_1, 32'h44);

    for (int n = 0; n < 150; n++) begin
      esc   = ($urandom_range(0, 2) == 0);
      lei   = ($urandom_range(0, 1) == 0);
      rsv   = ($urandom_range(0, 3) == 0);
      idreg = 3'($urandom_range(0, 7));
      idr   = 3'($urandom_range(0, 7));
      f1    = 3'($urandom_range(0, 7));
      f2    = 3'($urandom_range(0, 7));
      dado  = $urandom;
      cyc();
    end
    idle();

    lei = 1; f1 = 6; f2 = 6; cyc(); idle();
    chk("t9_v", 32'(v_1), 32'h1);
    rst = 1'b1; #1;
    chk("t9_rst_v", 32'(v_1), 32'h0);
    chk("t9_rst_d", q1_1, 32'h0);
    cyc();
    rst = 1'b0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
